// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard / forwarding controller.
package hazard_pkg;

  // E-stage ALU operand forward selects
  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Default mult/div latencies
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A producer "hits" a source when it writes a non-$0 register equal to it.
  function automatic logic reg_hit(input logic we, input logic [4:0] dst,
                                   input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer: busy is high for exactly N cycles after a start is
// sampled in IDLE. Starts seen while busy are ignored.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = ($clog2(MAXC) < 4) ? 4 : $clog2(MAXC);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  md_state_t     state;
  logic [CW-1:0] cnt;

  // Two-state FSM with a down-counter; busy is registered alongside state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state <= MD_BUSY;
          busy  <= 1'b1;
          cnt   <= is_div ? DIV_LD : MULT_LD;
        end
        MD_BUSY: if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Optional: define HAZARD_STATS_EN to build the saturating stall counter;
// otherwise stall_count is tied to zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  write_reg_E,
  input  logic [4:0]  write_reg_M,
  input  logic [4:0]  write_reg_W,
  input  logic        reg_write_E,
  input  logic        reg_write_M,
  input  logic        reg_write_W,
  input  logic        mem_to_reg_E,
  input  logic        mem_to_reg_M,
  input  logic        branch_D,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  output logic [1:0]  ForwardA_E,
  output logic [1:0]  ForwardB_E,
  output logic        ForwardA_D,
  output logic        ForwardB_D,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_E,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  logic lw_stall, br_stall, md_stall, stall;

  // E-stage forward selects; the younger result in M wins over W.
  always_comb begin
    ForwardA_E = FWD_RD;
    if (reg_hit(reg_write_M, write_reg_M, rs_E))      ForwardA_E = FWD_M;
    else if (reg_hit(reg_write_W, write_reg_W, rs_E)) ForwardA_E = FWD_W;
    ForwardB_E = FWD_RD;
    if (reg_hit(reg_write_M, write_reg_M, rt_E))      ForwardB_E = FWD_M;
    else if (reg_hit(reg_write_W, write_reg_W, rt_E)) ForwardB_E = FWD_W;
  end

  // Branch comparator bypass from the M-stage ALU result.
  always_comb begin
    ForwardA_D = reg_hit(reg_write_M, write_reg_M, rs_D);
    ForwardB_D = reg_hit(reg_write_M, write_reg_M, rt_D);
  end

  // Stall sources: load-use, branch operand not yet available, HI/LO busy.
  always_comb begin
    lw_stall = mem_to_reg_E && (reg_hit(reg_write_E, write_reg_E, rs_D) ||
                                reg_hit(reg_write_E, write_reg_E, rt_D));
    br_stall = branch_D && (reg_hit(reg_write_E, write_reg_E, rs_D)  ||
                            reg_hit(reg_write_E, write_reg_E, rt_D)  ||
                            reg_hit(mem_to_reg_M, write_reg_M, rs_D) ||
                            reg_hit(mem_to_reg_M, write_reg_M, rt_D));
    md_stall = md_use_D && (md_busy || md_start_E);
    stall    = lw_stall | br_stall | md_stall;
    stall_F  = stall;
    stall_D  = stall;
    flush_E  = stall;
  end

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (md_start_E),
    .is_div(md_is_div_E),
    .busy  (md_busy)
  );

`ifdef HAZARD_STATS_EN
  // Saturating count of cycles in which D was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    stall_count <= '0;
    else if (stall_D && (stall_count != '1))      stall_count <= stall_count + 32'd1;
  end
`else
  assign stall_count = '0;
`endif

endmodule
